// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared constants, state encoding and index helper for the fft16 loader
//
// Purpose:
//   Frame geometry constants (WIDTH, N, LOG2N), the loader state encoding,
//   and bitrev4(), which maps a sample number to its DIT input slot.
// Ports: none (package).

package fft16_pkg;

  localparam int WIDTH = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Reverse the bit order of a LOG2N-bit index (sample 1 -> slot 8, 3 -> 12).
  function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_input_loader.sv
// rtl/fft16_input_loader.sv - serial-to-parallel frame loader in front of the 16-point FFT
//
// Purpose:
//   Accepts one complex sample per cycle over a valid/ready handshake, collects
//   a 16-sample frame, then presents all 16 (re,im) pairs in parallel and holds
//   them until the downstream stage accepts the frame.
// Configuration:
//   FFT16_BITREV_EN defined -> sample k is stored in slot bitrev4(k) (DIT order).
//   FFT16_BITREV_EN undefined -> sample k is stored in slot k (natural order).
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous reset, active-low
//   in_valid   in   1          input sample valid
//   in_ready   out  1          loader can accept a sample (FILL and not in reset)
//   in_re      in   WIDTH      signed real part of sample
//   in_im      in   WIDTH      signed imaginary part of sample
//   in_last    in   1          final sample of a frame
//   out_valid  out  1          full frame presented on out_re/out_im
//   out_ready  in   1          downstream accepts the frame
//   out_re     out  N*WIDTH    slot k at [k*WIDTH +: WIDTH]
//   out_im     out  N*WIDTH    slot k at [k*WIDTH +: WIDTH]
//   frame_err  out  1          one-cycle pulse on a framing error

module fft16_input_loader
  import fft16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_re,
  input  logic [WIDTH-1:0]   in_im,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_re,
  output logic [N*WIDTH-1:0] out_im,
  output logic               frame_err
);

  state_t           state;
  state_t           state_nxt;
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] slot;
  logic             accept;
  logic             last_slot;
  logic             release_frame;

  // in_ready is gated by rst_n directly so it reads 0 for every cycle the
  // reset is held, and 1 as soon as it is released.
  assign in_ready      = rst_n && (state == ST_FILL);
  assign out_valid     = (state == ST_FULL);
  assign accept        = in_valid && in_ready;
  assign last_slot     = (wr_cnt == LOG2N'(N-1));
  assign release_frame = out_valid && out_ready;

`ifdef FFT16_BITREV_EN
  assign slot = bitrev4(wr_cnt);
`else
  assign slot = wr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (accept && last_slot) state_nxt = ST_FULL;
      ST_FULL: if (out_ready)           state_nxt = ST_FILL;
      default:                          state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      out_re    <= '0;
      out_im    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // Constant-index write decode keeps every slot a plain enabled register.
      for (int k = 0; k < N; k++) begin
        if (accept && (slot == LOG2N'(k))) begin
          out_re[k*WIDTH +: WIDTH] <= in_re;
          out_im[k*WIDTH +: WIDTH] <= in_im;
        end
      end

      if (accept) begin
        if (last_slot) begin
          // Counter parks at 15 while FULL; the release clears it.
          frame_err <= !in_last;
        end else if (in_last) begin
          // Early in_last: drop the partial frame and restart from slot 0.
          wr_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (release_frame) begin
        wr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft16_input_loader.sv
// tb/tb_fft16_input_loader.sv - self-checking bench for fft16_input_loader
//
// Purpose: table-driven framing scenarios, hand sequences for stall and
// mid-frame reset, and a randomized 100-frame scoreboard run.
// Ports: none (top-level bench). Honors FFT16_BITREV_EN like the design.

module tb_fft16_input_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_re;
  logic [15:0]  in_im;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_re;
  logic [255:0] out_im;
  logic         frame_err;

  fft16_input_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] sr [16];
  logic [15:0] si [16];

  typedef struct {
    int len;
    int lastpos;
    int pat;
    bit exp_err;
    bit exp_full;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_of(input int k);
    int r;
    r = k;
`ifdef FFT16_BITREV_EN
    r = 0;
    for (int b = 0; b < 4; b++) begin
      if (((k >> b) & 1) != 0) r = r + (1 << (3 - b));
    end
`endif
    return r;
  endfunction

  task automatic build(output logic [255:0] er, output logic [255:0] ei);
    er = '0;
    ei = '0;
    for (int k = 0; k < 16; k++) begin
      er[slot_of(k)*16 +: 16] = sr[k];
      ei[slot_of(k)*16 +: 16] = si[k];
    end
  endtask

  task automatic send_frame(input int len, input int lastpos, input int pat);
    for (int k = 0; k < len; k++) begin
      case (pat)
        0: begin sr[k] = 16'(k); si[k] = 16'(-k); end
        1: begin
          sr[k] = ((k % 2) == 1) ? 16'h8000 : 16'h7FFF;
          si[k] = ((k % 2) == 1) ? 16'h7FFF : 16'h8000;
        end
        default: begin sr[k] = 16'($urandom); si[k] = 16'($urandom); end
      endcase
      in_re    = sr[k];
      in_im    = si[k];
      in_valid = 1'b1;
      in_last  = (k == lastpos);
      step();
      if (k < len - 1) chk("no_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_and_release();
    logic [255:0] er, ei;
    build(er, ei);
    chk("frame_re", out_re, er);
    chk("frame_im", out_im, ei);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_frame_err", frame_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [7];
    logic [255:0] held_re, held_im, er, ei;
    logic [15:0]  mre [16];
    logic [15:0]  mim [16];
    logic [255:0] exp_re_q [$];
    logic [255:0] exp_im_q [$];
    int mcnt, sent_cnt, frames_sent, delivered, cycles;
    bit acc, rel;

    tbl[0] = '{16, 15, 0, 1'b0, 1'b1};
    tbl[1] = '{5,  4,  0, 1'b1, 1'b0};
    tbl[2] = '{16, 15, 1, 1'b0, 1'b1};
    tbl[3] = '{16, -1, 2, 1'b1, 1'b1};
    tbl[4] = '{1,  0,  2, 1'b1, 1'b0};
    tbl[5] = '{15, 14, 2, 1'b1, 1'b0};
    tbl[6] = '{16, 15, 2, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int t = 0; t < 7; t++) begin
      send_frame(tbl[t].len, tbl[t].lastpos, tbl[t].pat);
      chk("tbl_frame_err", frame_err, tbl[t].exp_err);
      chk("tbl_out_valid", out_valid, tbl[t].exp_full);
      if (tbl[t].exp_full) begin
        check_and_release();
      end else begin
        step();
        chk("err_pulse_end", frame_err, 0);
        chk("err_no_valid", out_valid, 0);
        chk("err_in_ready", in_ready, 1);
      end
    end

`ifdef FFT16_BITREV_EN
    send_frame(16, 15, 0);
    chk("bitrev_slot8_re", out_re[8*16 +: 16], 16'd1);
    chk("bitrev_slot8_im", out_im[8*16 +: 16], 16'hFFFF);
    chk("bitrev_slot12_re", out_re[12*16 +: 16], 16'd3);
    check_and_release();
`endif

    // Downstream stall: frame must hold and input must be refused.
    send_frame(16, 15, 2);
    held_re = out_re;
    held_im = out_im;
    in_valid = 1'b1;
    in_re = 16'h1234;
    in_im = 16'h5678;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    build(er, ei);
    chk("stall_hold_re", out_re, er);
    chk("stall_hold_im", out_im, ei);
    check_and_release();
    chk("no_clear_on_release_re", out_re, held_re);
    chk("no_clear_on_release_im", out_im, held_im);

    // Reset after 9 samples drops the frame and clears the slots.
    send_frame(9, -1, 2);
    rst_n = 1'b0;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_out_re", out_re, 0);
    chk("midrst_out_im", out_im, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", in_ready, 1);
    send_frame(16, 15, 2);
    chk("midrst_frame_valid", out_valid, 1);
    chk("midrst_frame_err2", frame_err, 0);
    check_and_release();

    // Randomized gaps on both sides, 100 clean frames through a scoreboard.
    mcnt = 0; sent_cnt = 0; frames_sent = 0; delivered = 0; cycles = 0;
    sr[0] = 16'($urandom);
    si[0] = 16'($urandom);
    while (delivered < 100 && cycles < 20000) begin
      in_valid  = (frames_sent < 100) && (($urandom % 4) != 0);
      in_re     = sr[0];
      in_im     = si[0];
      in_last   = (sent_cnt == 15);
      out_ready = (($urandom % 3) != 0);
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      if (rel) begin
        if (exp_re_q.size() == 0) begin
          chk("sb_spurious_frame", 1, 0);
        end else begin
          chk("sb_re", out_re, exp_re_q.pop_front());
          chk("sb_im", out_im, exp_im_q.pop_front());
        end
        delivered++;
      end
      step();
      cycles++;
      if (frame_err) chk("rand_frame_err", frame_err, 0);
      if (acc) begin
        mre[mcnt] = in_re;
        mim[mcnt] = in_im;
        mcnt++;
        if (mcnt == 16) begin
          er = '0;
          ei = '0;
          for (int k = 0; k < 16; k++) begin
            er[slot_of(k)*16 +: 16] = mre[k];
            ei[slot_of(k)*16 +: 16] = mim[k];
          end
          exp_re_q.push_back(er);
          exp_im_q.push_back(ei);
          mcnt = 0;
        end
        sent_cnt = (sent_cnt == 15) ? 0 : sent_cnt + 1;
        if (sent_cnt == 0) frames_sent++;
        sr[0] = 16'($urandom);
        si[0] = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_frames_delivered", 256'(delivered), 256'd100);
    chk("rand_queue_empty", 256'(exp_re_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
